acc_proc_core: RTL and testbench
================================

# acc_proc_core

Parametrised multi-cycle accumulator processor: the next generation of the team's 8-bit core. It generalises data width, register count and program-counter width, and it fetches instructions over a valid handshake instead of from a fixed internal array. It adds carry/zero flags, conditional branches and a clean halt state, and exposes external register-file preload and debug ports. It sits between an instruction-memory model or ROM and the system bench.

## Interface
- DATA_W, 8: accumulator, register and ALU width (≥4)
- REG_AW, 4: register address width; register file holds 2^REG_AW entries; instruction width is 4+REG_AW
- PC_W, 8: program counter width; instruction address space is 2^PC_W

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address, equals pc
- imem_valid  in  1  instruction present on imem_data this cycle
- imem_data  in  4+REG_AW  instruction, {opcode[3:0], reg}
- rf_we  in  1  external register preload strobe
- rf_waddr  in  REG_AW  preload address
- rf_wdata  in  DATA_W  preload data
- dbg_raddr  in  REG_AW  debug read address
- dbg_rdata  out  DATA_W  combinational register-file read
- acc  out  DATA_W  accumulator
- pc  out  PC_W  program counter
- flag_c, flag_z  out  1  carry and zero flags
- halted  out  1  core is in HALT

## Operation
- Opcodes (R = regfile[reg]):
  - 0 ADD: acc=acc+R
  - 1 SUB: acc=acc-R, C=borrow
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: acc<<1, C=msb out
  - 6 SHR: acc>>1, C=lsb out
  - 7 LDA: acc=R
  - 8 STA: R=acc
  - 9 JMP: pc=R[PC_W-1:0], zero-extended if DATA_W<PC_W
  - A JZ: jump if Z
  - B JC: jump if C
  - C CMP: flags of acc-R, acc unchanged
  - D MUL or NOP (see Configuration)
  - E NOP
  - F HLT
- Z = (new acc == 0) after ADD/SUB/AND/OR/XOR/SHL/SHR/LDA/MUL. For CMP, Z = (acc==R).
- C is written by ADD/SUB/SHL/SHR/CMP/MUL. Logic ops and LDA clear C.
- Flags are unchanged by STA, jumps, NOP and HLT.
- All arithmetic is modulo 2^DATA_W. ADD carry = bit DATA_W of the (DATA_W+1)-bit sum.
- FSM states FETCH, EXEC, HALT:
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid, latch instruction into ir, pc←pc+1 (wraps 2^PC_W−1→0), go to EXEC. Without valid, stay; all state holds.
  - EXEC: perform ir. A taken jump overwrites the incremented pc. HLT → HALT; otherwise → FETCH.
  - HALT: imem_req=0, terminal until reset.
- External preload: rf_we writes in any state. If it coincides with an STA write to the same address, STA wins. Different addresses: both write.

## Timing
- Reset values: state=FETCH, pc=0, acc=0, ir=0, flags=0, halted=0, imem_req=1 (combinational from state). Register file is not reset.
- Reset deassertion: first fetch of address 0 happens on the next clock edge with valid.
- Zero-wait memory: 2 cycles per instruction. Each stall cycle adds 1.
- Results (acc, flags, register writes, pc redirect) are visible the cycle after the EXEC edge. dbg_rdata reflects writes the cycle after.
- imem_data is sampled only in FETCH with imem_valid. Valid in any other state is ignored.
- Reset asserted mid-instruction aborts it immediately; no partial register write.
- halted is 1 from the cycle after HLT's EXEC edge.

## Configuration
- PROC_MUL_EN defined: opcode D = MUL; acc = low DATA_W bits of acc*R; C = OR of the high DATA_W bits; Z per rule.
- PROC_MUL_EN undefined: opcode D behaves exactly as NOP; no multiplier is synthesised.

## Structure
- Package acc_proc_pkg: opcode localparams/enum (OP_ADD…OP_HLT), state enum (S_FETCH, S_EXEC, S_HALT).
- Sub-module proc_regfile: 2^REG_AW×DATA_W array. Ports:
  - two write ports (internal, priority; external)
  - one combinational operand read
  - one combinational debug read
- The ALU stays inline in the core.

## Test plan
- Preload R1=5, R2=10; program LDA R1, ADD R2, STA R3, HLT, zero-wait → R3=15, acc=15, Z=0, C=0, halted after 8 cycles.
- acc=200 (LDA R4=200), ADD R5=100 → acc=44, C=1, Z=0. Then SUB R6=44 → acc=0, Z=1, C=0.
- LDA R0=0, JZ R7=0x0A → next imem_addr=0x0A. Repeat with Z=0 → imem_addr=pc+1.
- imem_valid held low 5 cycles during FETCH → pc, acc unchanged, imem_req held 1. Instruction completes after valid.
- pc=0xFF NOP, no jump → next fetch at 0x00. Reset asserted during EXEC of STA → target register unchanged, pc=0, acc=0.
- With PROC_MUL_EN: acc=20, MUL R(=16) → acc=0x40, C=1. Without the macro: acc stays 20, flags unchanged.

Source files
------------

// File: rtl/acc_proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_proc_pkg
// Purpose  : Shared opcode and FSM state encodings for the accumulator core.
// Revision : 1.0 - initial release
// ============================================================================
package acc_proc_pkg;

    // Width of the opcode field at the top of every instruction word
    localparam int unsigned c_OPC_W = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_AND = 4'h2,
        OP_OR  = 4'h3,
        OP_XOR = 4'h4,
        OP_SHL = 4'h5,
        OP_SHR = 4'h6,
        OP_LDA = 4'h7,
        OP_STA = 4'h8,
        OP_JMP = 4'h9,
        OP_JZ  = 4'hA,
        OP_JC  = 4'hB,
        OP_CMP = 4'hC,
        OP_MUL = 4'hD,
        OP_NOP = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/proc_regfile.sv
`default_nettype none
// ============================================================================
// Module   : proc_regfile
// Purpose  : 2^REG_AW x DATA_W register file, no reset. Two write ports
//            (core-internal has priority over external preload on the same
//            address), one operand read and one debug read, both
//            combinational.
// Revision : 1.0 - initial release
// ============================================================================
module proc_regfile
    import acc_proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              i_int_we,
    input  logic [REG_AW-1:0] i_int_waddr,
    input  logic [DATA_W-1:0] i_int_wdata,
    input  logic              i_ext_we,
    input  logic [REG_AW-1:0] i_ext_waddr,
    input  logic [DATA_W-1:0] i_ext_wdata,
    input  logic [REG_AW-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    localparam int c_DEPTH = 1 << REG_AW;

    logic [DATA_W-1:0] r_mem [c_DEPTH];
    logic              w_ext_blocked;

    // An external preload loses to a same-cycle core write of the same entry
    assign w_ext_blocked = i_int_we && (i_int_waddr == i_ext_waddr);

    // Storage update: both ports may write in one cycle to distinct entries
    always_ff @(posedge clk) begin
        if (i_ext_we && !w_ext_blocked) begin
            r_mem[i_ext_waddr] <= i_ext_wdata;
        end
        if (i_int_we) begin
            r_mem[i_int_waddr] <= i_int_wdata;
        end
    end

    assign o_rd_data  = r_mem[i_rd_addr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/acc_proc_core.sv
`default_nettype none
// ============================================================================
// Module   : acc_proc_core
// Purpose  : Multi-cycle accumulator processor. FETCH latches an instruction
//            over a valid handshake, EXEC performs it, HLT parks the core in
//            HALT until reset. Carry/zero flags, conditional jumps, external
//            register preload and a debug read port.
// Options  : PROC_MUL_EN - when defined, opcode D is MUL; otherwise it is a
//            NOP and no multiplier exists.
// Revision : 1.0 - initial release
// ============================================================================
module acc_proc_core
    import acc_proc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 4,
    parameter int PC_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [PC_W-1:0]           imem_addr,
    input  logic                      imem_valid,
    input  logic [c_OPC_W+REG_AW-1:0] imem_data,
    input  logic                      rf_we,
    input  logic [REG_AW-1:0]         rf_waddr,
    input  logic [DATA_W-1:0]         rf_wdata,
    input  logic [REG_AW-1:0]         dbg_raddr,
    output logic [DATA_W-1:0]         dbg_rdata,
    output logic [DATA_W-1:0]         acc,
    output logic [PC_W-1:0]           pc,
    output logic                      flag_c,
    output logic                      flag_z,
    output logic                      halted
);

    localparam int c_IR_W = c_OPC_W + REG_AW;

    state_e              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_acc;
    logic [c_IR_W-1:0]   r_ir;
    logic                r_c;
    logic                r_z;
    logic                r_halted;

    opcode_e             w_op;
    logic [REG_AW-1:0]   w_reg;
    logic [DATA_W-1:0]   w_opnd;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [PC_W-1:0]     w_jmp_tgt;
    logic [DATA_W-1:0]   w_acc_nx;
    logic                w_c_nx;
    logic                w_z_nx;
    logic                w_set_z;
    logic                w_jump;
    logic                w_sta;

    assign w_op  = opcode_e'(r_ir[c_IR_W-1 -: c_OPC_W]);
    assign w_reg = r_ir[REG_AW-1:0];

    proc_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk         (clk),
        .i_int_we    ((r_state == S_EXEC) && w_sta),
        .i_int_waddr (w_reg),
        .i_int_wdata (r_acc),
        .i_ext_we    (rf_we),
        .i_ext_waddr (rf_waddr),
        .i_ext_wdata (rf_wdata),
        .i_rd_addr   (w_reg),
        .o_rd_data   (w_opnd),
        .i_dbg_addr  (dbg_raddr),
        .o_dbg_data  (dbg_rdata)
    );

    // Jump target: low PC_W bits of the register, zero-extended if narrower
    generate
        if (DATA_W >= PC_W) begin : g_tgt_trunc
            assign w_jmp_tgt = w_opnd[PC_W-1:0];
        end else begin : g_tgt_zext
            assign w_jmp_tgt = {{(PC_W-DATA_W){1'b0}}, w_opnd};
        end
    endgenerate

    // Extra bit on the top catches the add carry / subtract borrow
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_opnd};
    assign w_diff = {1'b0, r_acc} - {1'b0, w_opnd};

`ifdef PROC_MUL_EN
    logic [2*DATA_W-1:0] w_prod;
    assign w_prod = {{DATA_W{1'b0}}, r_acc} * {{DATA_W{1'b0}}, w_opnd};
`endif

    // ALU: next accumulator, flags, store strobe and jump decision for ir
    always_comb begin
        w_acc_nx = r_acc;
        w_c_nx   = r_c;
        w_z_nx   = r_z;
        w_set_z  = 1'b0;
        w_jump   = 1'b0;
        w_sta    = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_acc_nx = w_sum[DATA_W-1:0];
                w_c_nx   = w_sum[DATA_W];
                w_set_z  = 1'b1;
            end
            OP_SUB: begin
                w_acc_nx = w_diff[DATA_W-1:0];
                w_c_nx   = w_diff[DATA_W];
                w_set_z  = 1'b1;
            end
            OP_AND: begin
                w_acc_nx = r_acc & w_opnd;
                w_c_nx   = 1'b0;
                w_set_z  = 1'b1;
            end
            OP_OR: begin
                w_acc_nx = r_acc | w_opnd;
                w_c_nx   = 1'b0;
                w_set_z  = 1'b1;
            end
            OP_XOR: begin
                w_acc_nx = r_acc ^ w_opnd;
                w_c_nx   = 1'b0;
                w_set_z  = 1'b1;
            end
            OP_SHL: begin
                w_acc_nx = {r_acc[DATA_W-2:0], 1'b0};
                w_c_nx   = r_acc[DATA_W-1];
                w_set_z  = 1'b1;
            end
            OP_SHR: begin
                w_acc_nx = {1'b0, r_acc[DATA_W-1:1]};
                w_c_nx   = r_acc[0];
                w_set_z  = 1'b1;
            end
            OP_LDA: begin
                w_acc_nx = w_opnd;
                w_c_nx   = 1'b0;
                w_set_z  = 1'b1;
            end
            OP_STA: w_sta  = 1'b1;
            OP_JMP: w_jump = 1'b1;
            OP_JZ:  w_jump = r_z;
            OP_JC:  w_jump = r_c;
            OP_CMP: begin
                w_c_nx = w_diff[DATA_W];
                w_z_nx = (r_acc == w_opnd);
            end
`ifdef PROC_MUL_EN
            OP_MUL: begin
                w_acc_nx = w_prod[DATA_W-1:0];
                w_c_nx   = |w_prod[2*DATA_W-1:DATA_W];
                w_set_z  = 1'b1;
            end
`else
            OP_MUL: begin
            end
`endif
            OP_NOP: begin
            end
            OP_HLT: begin
            end
            default: begin
            end
        endcase
        if (w_set_z) begin
            w_z_nx = (w_acc_nx == '0);
        end
    end

    // Control FSM and architectural state; reset aborts any instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_acc    <= '0;
            r_ir     <= '0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir    <= imem_data;
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_acc <= w_acc_nx;
                    r_c   <= w_c_nx;
                    r_z   <= w_z_nx;
                    if (w_jump) begin
                        r_pc <= w_jmp_tgt;
                    end
                    if (w_op == OP_HLT) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign acc       = r_acc;
    assign flag_c    = r_c;
    assign flag_z    = r_z;
    assign halted    = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_acc_proc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_proc_core
// Purpose  : Scoreboard bench for acc_proc_core. The instruction-memory driver
//            runs a behavioural model on every accepted fetch and queues the
//            expected architectural state; a monitor pops and compares it the
//            cycle after each EXEC edge. Directed programs plus random ones.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_proc_core;

    localparam int DATA_W = 8;
    localparam int REG_AW = 4;
    localparam int PC_W   = 8;
    localparam int IW     = 4 + REG_AW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_valid = 1'b0;
    logic [IW-1:0]     imem_data = '0;
    logic              rf_we = 1'b0;
    logic [REG_AW-1:0] rf_waddr = '0;
    logic [DATA_W-1:0] rf_wdata = '0;
    logic [REG_AW-1:0] dbg_raddr = '0;
    logic [DATA_W-1:0] dbg_rdata;
    logic [DATA_W-1:0] acc;
    logic [PC_W-1:0]   pc;
    logic              flag_c;
    logic              flag_z;
    logic              halted;

    always #5 clk = ~clk;

    acc_proc_core #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .PC_W   (PC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata),
        .acc        (acc),
        .pc         (pc),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .halted     (halted)
    );

    typedef struct {
        int acc;
        int c;
        int z;
        int pc;
        int halt;
        int dreg;
        int dval;
    } exp_t;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    bit   mon_en = 1'b1;
    bit   prev_exec = 1'b0;

    // Reference model state
    int   m_acc, m_c, m_z, m_pc, m_halt;
    int   m_rf [16];
    logic [IW-1:0] prog [256];

    function automatic void check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endfunction

    function automatic logic [IW-1:0] ins(int op, int r);
        logic [IW-1:0] v;
        v = IW'((op % 16) * 16 + (r % 16));
        return v;
    endfunction

    function automatic void model_reset();
        m_acc = 0; m_c = 0; m_z = 0; m_pc = 0; m_halt = 0;
    endfunction

    // Executes one instruction by the ISA rules and queues the expected state
    function automatic void model_exec(int instr);
        int   op, r, rv, p;
        exp_t e;
        op   = instr / 16;
        r    = instr % 16;
        rv   = m_rf[r];
        m_pc = (m_pc + 1) % 256;
        case (op)
            0:  begin p = m_acc + rv; m_c = (p > 255); m_acc = p % 256; m_z = (m_acc == 0); end
            1:  begin m_c = (m_acc < rv); m_acc = (m_acc - rv + 256) % 256; m_z = (m_acc == 0); end
            2:  begin m_acc = m_acc & rv; m_c = 0; m_z = (m_acc == 0); end
            3:  begin m_acc = m_acc | rv; m_c = 0; m_z = (m_acc == 0); end
            4:  begin m_acc = m_acc ^ rv; m_c = 0; m_z = (m_acc == 0); end
            5:  begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; m_z = (m_acc == 0); end
            6:  begin m_c = m_acc % 2; m_acc = m_acc / 2; m_z = (m_acc == 0); end
            7:  begin m_acc = rv; m_c = 0; m_z = (m_acc == 0); end
            8:  m_rf[r] = m_acc;
            9:  m_pc = rv % 256;
            10: if (m_z != 0) m_pc = rv % 256;
            11: if (m_c != 0) m_pc = rv % 256;
            12: begin m_c = (m_acc < rv); m_z = (m_acc == rv); end
`ifdef PROC_MUL_EN
            13: begin p = m_acc * rv; m_c = (p >= 256); m_acc = p % 256; m_z = (m_acc == 0); end
`endif
            15: m_halt = 1;
            default: ;
        endcase
        e.acc = m_acc; e.c = m_c; e.z = m_z; e.pc = m_pc; e.halt = m_halt;
        e.dreg = r; e.dval = m_rf[r];
        sb.push_back(e);
    endfunction

    // Monitor: after every EXEC edge compare DUT state with the queue head
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && prev_exec) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_exec @%0t: got exec, want none", $time);
                end else begin
                    e = sb.pop_front();
                    check("acc",    int'(acc),       e.acc);
                    check("flag_c", int'(flag_c),    e.c);
                    check("flag_z", int'(flag_z),    e.z);
                    check("pc",     int'(imem_addr), e.pc);
                    check("halted", int'(halted),    e.halt);
                    check($sformatf("reg%0d", e.dreg), int'(dbg_rdata), e.dval);
                end
            end
            prev_exec = mon_en && rst && !imem_req && !halted;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input int a, input int d);
        @(negedge clk);
        rf_we    = 1'b1;
        rf_waddr = REG_AW'(a);
        rf_wdata = DATA_W'(d);
        m_rf[a]  = d;
        @(negedge clk);
        rf_we    = 1'b0;
    endtask

    task automatic enter_reset(input logic [IW-1:0] fill);
        @(negedge clk);
        rst        = 1'b0;
        imem_valid = 1'b0;
        rf_we      = 1'b0;
        sb.delete();
        model_reset();
        for (int i = 0; i < 256; i++) prog[i] = fill;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Instruction-memory driver; the model runs for each accepted fetch
    task automatic run_prog(input int max_cyc, input int stall_pct,
                            input bit extras, output int cyc);
        bit pend_sta;
        int sta_reg, a, d, instr;
        cyc      = 0;
        pend_sta = 1'b0;
        sta_reg  = 0;
        while (cyc < max_cyc && !halted) begin
            rf_we = 1'b0;
            if (pend_sta && extras && ($urandom_range(1) == 1)) begin
                a = ($urandom_range(1) == 1) ? sta_reg : int'($urandom_range(15));
                d = int'($urandom_range(255));
                rf_we    = 1'b1;
                rf_waddr = REG_AW'(a);
                rf_wdata = DATA_W'(d);
                if (a != sta_reg) m_rf[a] = d;
            end
            pend_sta = 1'b0;
            if (imem_req) begin
                imem_valid = (int'($urandom_range(99)) >= stall_pct);
                imem_data  = prog[imem_addr];
                if (imem_valid) begin
                    instr     = int'(imem_data);
                    dbg_raddr = REG_AW'(instr % 16);
                    model_exec(instr);
                    pend_sta  = (instr / 16 == 8);
                    sta_reg   = instr % 16;
                end
            end else begin
                imem_valid = extras ? ($urandom_range(1) == 1) : 1'b0;
                imem_data  = IW'($urandom_range(255));
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        imem_valid = 1'b0;
        rf_we      = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("final_pc", int'(imem_addr), m_pc);
    endtask

    initial begin : main
        int cyc;
        int r;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_acc",    int'(acc),      0);
        check("rst_pc",     int'(pc),       0);
        check("rst_req",    int'(imem_req), 1);
        check("rst_halted", int'(halted),   0);
        check("rst_c",      int'(flag_c),   0);
        check("rst_z",      int'(flag_z),   0);

        // LDA R1, ADD R2, STA R3, HLT with zero-wait memory
        enter_reset(ins(15, 0));
        prog[0] = ins(7, 1); prog[1] = ins(0, 2); prog[2] = ins(8, 3); prog[3] = ins(15, 0);
        preload(1, 5); preload(2, 10);
        leave_reset();
        run_prog(100, 0, 1'b0, cyc);
        dbg_raddr = 4'd3;
        #1;
        check("t1_r3",     int'(dbg_rdata), 15);
        check("t1_acc",    int'(acc),       15);
        check("t1_z",      int'(flag_z),    0);
        check("t1_c",      int'(flag_c),    0);
        check("t1_halted", int'(halted),    1);
        check("t1_cycles", cyc,             8);

        // ADD with carry-out, then SUB to zero
        enter_reset(ins(15, 0));
        prog[0] = ins(7, 4); prog[1] = ins(0, 5); prog[2] = ins(1, 6); prog[3] = ins(15, 0);
        preload(4, 200); preload(5, 100); preload(6, 44);
        leave_reset();
        run_prog(100, 0, 1'b0, cyc);
        check("t2_acc", int'(acc),    0);
        check("t2_z",   int'(flag_z), 1);
        check("t2_c",   int'(flag_c), 0);

        // JZ taken and not taken
        for (int k = 0; k < 2; k++) begin
            enter_reset(ins(15, 0));
            prog[0] = ins(7, 0); prog[1] = ins(10, 7);
            preload(0, k); preload(7, 8'h0A);
            leave_reset();
            run_prog(100, 0, 1'b0, cyc);
            check($sformatf("t3_jz_pc_%0d", k), int'(pc), (k == 0) ? 8'h0B : 8'h03);
        end

        // Fetch stall: five cycles without valid hold everything
        enter_reset(ins(15, 0));
        prog[0] = ins(7, 1); prog[1] = ins(15, 0);
        preload(1, 9);
        leave_reset();
        for (int i = 0; i < 5; i++) begin
            imem_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check("t4_stall_req", int'(imem_req), 1);
            check("t4_stall_pc",  int'(pc),       0);
            check("t4_stall_acc", int'(acc),      0);
        end
        run_prog(100, 0, 1'b0, cyc);
        check("t4_acc", int'(acc), 9);

        // pc wrap from 0xFF to 0x00, then JC taken
        enter_reset(ins(15, 0));
        prog[0] = ins(11, 2); prog[1] = ins(7, 1); prog[2] = ins(5, 0);
        prog[3] = ins(9, 1);  prog[8'hFF] = ins(14, 0);
        preload(1, 8'hFF); preload(2, 8'h10);
        leave_reset();
        run_prog(200, 0, 1'b0, cyc);
        check("t5_pc",     int'(pc),     8'h11);
        check("t5_halted", int'(halted), 1);

        // MUL (or NOP without the multiplier)
        enter_reset(ins(15, 0));
        prog[0] = ins(7, 1); prog[1] = ins(13, 2); prog[2] = ins(15, 0);
        preload(1, 20); preload(2, 16);
        leave_reset();
        run_prog(100, 0, 1'b0, cyc);
`ifdef PROC_MUL_EN
        check("t7_acc", int'(acc),    8'h40);
        check("t7_c",   int'(flag_c), 1);
`else
        check("t7_acc", int'(acc),    20);
        check("t7_c",   int'(flag_c), 0);
`endif
        check("t7_z", int'(flag_z), 0);

        // Reset during EXEC of STA: store must be abandoned
        mon_en = 1'b0;
        enter_reset(ins(15, 0));
        prog[0] = ins(7, 1); prog[1] = ins(8, 3);
        preload(1, 8'h77); preload(3, 8'h11);
        leave_reset();
        imem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            imem_data = prog[imem_addr];
            @(posedge clk);
            @(negedge clk);
        end
        imem_valid = 1'b0;
        check("t6_in_exec", int'(imem_req), 0);
        check("t6_acc_pre", int'(acc),      8'h77);
        rst = 1'b0;
        #1;
        check("t6_pc",  int'(pc),       0);
        check("t6_acc", int'(acc),      0);
        check("t6_req", int'(imem_req), 1);
        @(posedge clk);
        @(negedge clk);
        dbg_raddr = 4'd3;
        #1;
        check("t6_r3", int'(dbg_rdata), 8'h11);
        @(negedge clk);
        mon_en = 1'b1;

        // Random programs with stalls, stray valids and preload collisions
        for (int t = 0; t < 10; t++) begin
            enter_reset(ins(15, 0));
            for (int i = 0; i < 256; i++) begin
                r = int'($urandom_range(15));
                if (r == 15 && $urandom_range(3) != 0) r = 14;
                prog[i] = ins(r, int'($urandom_range(15)));
            end
            for (int i = 0; i < 16; i++) preload(i, int'($urandom_range(255)));
            leave_reset();
            run_prog(400, 25, 1'b1, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
